set_reset_register_bank_with_asynchronous_reset: RTL
====================================================

Name: set_reset_register_bank_with_asynchronous_reset

Overview:
- Parametrised, multi-bit generalisation of the single SR flip-flop: a bank of WIDTH independent set/reset state bits.
- Adds a selectable set/reset conflict policy, optional rising-edge qualification of set, a synchronous bank-wide clear, per-bit sticky overrun flags and a masked interrupt summary.
- Used as an event or status register behind interrupt controllers and error collectors.

Parameters:
- WIDTH, 8, number of state bits (≥1).
- RESET_VALUE, 0, WIDTH-bit value loaded into state on resetn low.
- CONFLICT_MODE, 0, policy when set and reset are both active on one bit: 0 set wins, 1 reset wins, 2 toggle, 3 hold.
- SET_EDGE, 0, 0 = set is level-sensitive, 1 = only a rising edge of set counts.
- OVERRUN_ENABLE, 1, 1 = implement overrun flags, 0 = overrun tied to 0 and its registers removed.

Ports:
- clock  input  1  single clock, all state updates on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- set  input  WIDTH  per-bit set request.
- reset  input  WIDTH  per-bit reset request.
- clear_all  input  1  synchronous clear of state and overrun, all bits.
- mask  input  WIDTH  interrupt enable per bit.
- state  output  WIDTH  registered state bits.
- overrun  output  WIDTH  sticky flag: a set event hit a bit that was already 1.
- interrupt  output  1  OR of (state AND mask).

Behaviour:
- Reset: resetn is asynchronous and active-low. Asserting it immediately forces:
  - state = RESET_VALUE
  - overrun = 0
  - the set history register set_q = 0
  Release takes effect on the next rising clock edge.
- Effective set, se:
  - SET_EDGE=0: se = set.
  - SET_EDGE=1: se = set AND NOT set_q, where set_q is the value of set registered every cycle.
  - Because set_q resets to 0, a set input held high across reset release produces one event on the first edge after release.
- Per-bit next state, evaluated in priority order:
  1. clear_all=1 → 0 (also overrides set/reset).
  2. se only → 1.
  3. reset only → 0.
  4. se and reset together → decided by CONFLICT_MODE: 0 → 1; 1 → 0; 2 → NOT state; 3 → state unchanged.
  5. Neither → hold.
- Latency: state changes one edge after the request is sampled. There is no combinational path from set/reset to state.
- Overrun, per bit, when OVERRUN_ENABLE=1:
  - Goes to 1 on an edge where se=1 and state=1, and the bit's next state is 1 after conflict resolution.
  - Once 1, it holds.
  - Cleared to 0 by clear_all, or by any edge where the bit's next state is 0 (reset, or toggle to 0).
  - Clear takes precedence over a same-cycle overrun.
  - In CONFLICT_MODE 2, a toggle of a 1 bit is a clear, not an overrun.
- Interrupt:
  - interrupt = |(state & mask). Combinational from the state registers and mask, with no added latency.
  - A mask change affects interrupt in the same cycle.
- Bits are fully independent. Any mix of set/reset across bits in one cycle is legal.
- WIDTH=1, CONFLICT_MODE=0, SET_EDGE=0 with clear_all=0 matches the single SR flip-flop, including set priority.

Test Plan:
- Reset value: RESET_VALUE=8'hA5; assert resetn mid-cycle with no clock → state=A5 and overrun=00 immediately; after release with inputs 0, state holds A5.
- Set/reset basic: set=8'h0F for 1 cycle → state=0F next edge; then reset=8'h03 → state=0C; inputs idle for 5 cycles → holds 0C.
- Conflict modes: state=8'h01, set=reset=8'h03 for one edge. Required state per mode:
  - CONFLICT_MODE 0 → 03
  - CONFLICT_MODE 1 → 00
  - CONFLICT_MODE 2 → 02
  - CONFLICT_MODE 3 → 01
- Edge mode: SET_EDGE=1, reset=8'h01 to clear bit 0, then hold set[0]=1 for 4 cycles.
  - Bit 0 sets once on the first edge.
  - Reset bit 0 while set stays high → stays 0.
  - Drop set and raise it again → sets again.
  - Separately, set held high across reset release → bit sets on the first edge.
- Overrun: set[2] pulses on two edges with state[2]=1 → overrun=8'h04. A further set keeps 04. reset[2] → overrun=00 and state[2]=0. set together with clear_all → state=00, overrun=00.
- Interrupt/mask: state=8'h10, mask=00 → interrupt=0. mask=10 → interrupt=1 in the same cycle. clear_all → interrupt=0 after the edge.

Source files
------------

// File: rtl/set_reset_register_bank_with_asynchronous_reset.sv
// Bank of WIDTH independent set/reset state bits with conflict policy, optional
// set edge qualification, bank clear, sticky overrun flags and masked interrupt.

module srrb_bit #(
  parameter int   CONFLICT_MODE  = 0,
  parameter int   SET_EDGE       = 0,
  parameter int   OVERRUN_ENABLE = 1,
  parameter logic RST_BIT        = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic set_i,
  input  logic reset_i,
  input  logic clear_all_i,
  output logic state_o,
  output logic overrun_o
);

  logic se;
  logic state_q, state_d;
  logic both_v;

  // set_q only exists when set must be edge-qualified; it resets to 0 so a set
  // held across reset release still yields one event.
  generate
    if (SET_EDGE != 0) begin : g_edge
      logic set_q;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) set_q <= 1'b0;
        else         set_q <= set_i;
      end
      assign se = set_i & ~set_q;
    end else begin : g_lvl
      assign se = set_i;
    end
  endgenerate

  always_comb begin
    both_v = state_q;
    case (CONFLICT_MODE)
      0:       both_v = 1'b1;
      1:       both_v = 1'b0;
      2:       both_v = ~state_q;
      default: both_v = state_q;
    endcase

    state_d = state_q;
    if (clear_all_i)          state_d = 1'b0;
    else if (se && reset_i)   state_d = both_v;
    else if (se)              state_d = 1'b1;
    else if (reset_i)         state_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= RST_BIT;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

  // Overrun survives only while the bit's next state is 1, so any clearing
  // edge (clear_all, reset, toggle to 0) wins over a same-cycle overrun.
  generate
    if (OVERRUN_ENABLE != 0) begin : g_ovr
      logic ovr_q, ovr_d;
      assign ovr_d = (ovr_q | (se & state_q)) & state_d;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) ovr_q <= 1'b0;
        else         ovr_q <= ovr_d;
      end
      assign overrun_o = ovr_q;
    end else begin : g_no_ovr
      assign overrun_o = 1'b0;
    end
  endgenerate

endmodule

module set_reset_register_bank_with_asynchronous_reset #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter int               CONFLICT_MODE  = 0,
  parameter int               SET_EDGE       = 0,
  parameter int               OVERRUN_ENABLE = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  input  logic             clear_all,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] overrun,
  output logic             interrupt
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      srrb_bit #(
        .CONFLICT_MODE (CONFLICT_MODE),
        .SET_EDGE      (SET_EDGE),
        .OVERRUN_ENABLE(OVERRUN_ENABLE),
        .RST_BIT       (RESET_VALUE[i])
      ) u_bit (
        .clock      (clock),
        .resetn     (resetn),
        .set_i      (set[i]),
        .reset_i    (reset[i]),
        .clear_all_i(clear_all),
        .state_o    (state[i]),
        .overrun_o  (overrun[i])
      );
    end
  endgenerate

  assign interrupt = |(state & mask);

endmodule
